// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit: op codes, flag bundle,
// per-stage control word and op-decoding helpers.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBB = 2'b11
    } op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic valid;
        op_t  op;
        logic carry;
    } stage_ctl_t;

    function automatic logic invert_b(input op_t op);
        return (op == SUB) || (op == SBB);
    endfunction

    // SBB treats cin=1 as "no borrow", so ADC and SBB both pass cin straight through.
    function automatic logic carry_in(input op_t op, input logic cin);
        logic c;
        case (op)
            ADD:     c = 1'b0;
            SUB:     c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational carry-lookahead adder for one CW-bit pipeline chunk, built
// from GROUP-bit lookahead groups with group-level generate/propagate.
module cla_chunk #(
    parameter int CW    = 8,
    parameter int GROUP = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          a_msb,
    output logic          b_msb
);

    localparam int NG = CW / GROUP;

    logic [CW-1:0] g;
    logic [CW-1:0] p;

    assign g     = a & b;
    assign p     = a ^ b;
    assign a_msb = a[CW-1];
    assign b_msb = b[CW-1];

    // Group carry-in skips over each group via its G/P pair; bit carries are local.
    always_comb begin
        logic grp_carry;
        logic bit_carry;
        logic grp_g;
        logic grp_p;
        sum       = '0;
        grp_carry = cin;
        for (int j = 0; j < NG; j++) begin
            grp_g     = 1'b0;
            grp_p     = 1'b1;
            bit_carry = grp_carry;
            for (int i = 0; i < GROUP; i++) begin
                sum[j*GROUP+i] = p[j*GROUP+i] ^ bit_carry;
                bit_carry      = g[j*GROUP+i] | (p[j*GROUP+i] & bit_carry);
                grp_g          = g[j*GROUP+i] | (p[j*GROUP+i] & grp_g);
                grp_p          = grp_p & p[j*GROUP+i];
            end
            grp_carry = grp_g | (grp_p & grp_carry);
        end
        cout = grp_carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// STAGES-deep pipelined add/sub with valid/ready handshake and N/Z/C/V flags.
// Optional output clamping on signed overflow: PIPELINED_ADDSUB_SATURATE_EN.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v
);

    localparam int CW = WIDTH / STAGES;

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        flags_t           flags;
    } stage_t;

    stage_t stage_reg  [STAGES];
    stage_t stage_next [STAGES];
    stage_t head;
    op_t    op;
    logic   en;

    assign op       = op_t'(in_op);
    assign en       = !stage_reg[STAGES-1].ctl.valid || out_ready;
    assign in_ready = en;

    // Operands enter with B already conditioned, so every stage is a plain add.
    always_comb begin
        head           = '0;
        head.ctl.valid = in_valid;
        head.ctl.op    = op;
        head.ctl.carry = carry_in(op, in_cin);
        head.a         = in_a;
        head.b         = invert_b(op) ? ~in_b : in_b;
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            stage_t          src;
            stage_t          nxt;
            logic [CW-1:0]   chunk_sum;
            logic            chunk_cout;
            logic            msb_a;
            logic            msb_b;

            if (gi == 0) begin : g_first
                assign src = head;
            end else begin : g_rest
                assign src = stage_reg[gi-1];
            end

            cla_chunk #(
                .CW    (CW),
                .GROUP (GROUP)
            ) u_chunk (
                .a     (src.a[gi*CW +: CW]),
                .b     (src.b[gi*CW +: CW]),
                .cin   (src.ctl.carry),
                .sum   (chunk_sum),
                .cout  (chunk_cout),
                .a_msb (msb_a),
                .b_msb (msb_b)
            );

`ifdef PIPELINED_ADDSUB_SATURATE_EN
            localparam bit LAST = (gi == STAGES - 1);
`endif

            // Flags are evaluated every stage; only the last stage's values are exported.
            always_comb begin
                nxt                    = src;
                nxt.sum[gi*CW +: CW]   = chunk_sum;
                nxt.ctl.carry          = chunk_cout;
                nxt.flags.c            = chunk_cout;
                nxt.flags.v            = (msb_a == msb_b) && (chunk_sum[CW-1] != msb_a);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
                if (LAST && nxt.flags.v) begin
                    nxt.sum = msb_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
                nxt.flags.n            = nxt.sum[WIDTH-1];
                nxt.flags.z            = (nxt.sum == '0);
            end

            assign stage_next[gi] = nxt;
        end
    endgenerate

    // One enable freezes the whole pipe, so a stalled result never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= stage_next[k];
            end
        end
    end

    assign out_valid = stage_reg[STAGES-1].ctl.valid;
    assign out_sum   = stage_reg[STAGES-1].sum;
    assign out_n     = stage_reg[STAGES-1].flags.n;
    assign out_z     = stage_reg[STAGES-1].flags.z;
    assign out_c     = stage_reg[STAGES-1].flags.c;
    assign out_v     = stage_reg[STAGES-1].flags.v;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed table, reset-mid-flight, back-pressure
// and randomized traffic checked against an arithmetic reference model.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int W = 16;
    localparam int S = 2;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_op = 2'b00;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_n, out_z, out_c, out_v;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(S), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_n     (out_n),
        .out_z     (out_z),
        .out_c     (out_c),
        .out_v     (out_v)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic n, z, c, v;
    } res_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [1:0]   op;
        logic         cin;
        res_t         exp;
    } vec_t;

    typedef struct {
        res_t exp;
        int   issue_cyc;
    } sb_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   lat_check = 1'b1;
    int   ready_mode = 0;
    res_t cur_exp;
    sb_t  sbq[$];
    bit   stalled = 1'b0;
    res_t held;
    res_t got;
    sb_t  ent;

    // Reference: unsigned sum for carry, signed sum for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic cin);
        longint m    = longint'(1) << W;
        longint half = longint'(1) << (W - 1);
        longint ua, ub, ci, full, sa, sb, sres;
        res_t   r;
        ua   = longint'(a);
        ub   = (op == 2'b01 || op == 2'b11) ? (m - 1 - longint'(b)) : longint'(b);
        ci   = (op == 2'b00) ? 0 : (op == 2'b01) ? 1 : longint'(cin);
        full = ua + ub + ci;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        sres = sa + sb + ci;
        r.c  = (full >= m);
        r.v  = (sres > half - 1) || (sres < -half);
        r.sum = W'(full % m);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (r.v) r.sum = (sres > 0) ? W'(half - 1) : W'(half);
`endif
        r.n = r.sum[W-1];
        r.z = (r.sum == '0);
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] op, input logic cin, input logic [W-1:0] sum,
                                input logic n, input logic z, input logic c, input logic v);
        vec_t t;
        t.a = a; t.b = b; t.op = op; t.cin = cin;
        t.exp.sum = sum; t.exp.n = n; t.exp.z = z; t.exp.c = c; t.exp.v = v;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard: input transfers push, output transfers pop and compare.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sbq.delete();
            stalled = 1'b0;
        end else begin
            got = '{out_sum, out_n, out_z, out_c, out_v};
            if (stalled) begin
                n_vec++;
                if (!out_valid || got !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b %h, expected v=1 %h", out_valid, got, held);
                end
            end
            if (in_valid && in_ready) sbq.push_back('{cur_exp, cyc});
            if (out_valid && out_ready) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got %h, expected none", got);
                end else begin
                    ent = sbq.pop_front();
                    if (got !== ent.exp) begin
                        n_bad++;
                        $display("FAIL result: got sum=%h nzcv=%b%b%b%b, expected sum=%h nzcv=%b%b%b%b",
                                 got.sum, got.n, got.z, got.c, got.v,
                                 ent.exp.sum, ent.exp.n, ent.exp.z, ent.exp.c, ent.exp.v);
                    end else begin
                        $display("ok   sum=%h nzcv=%b%b%b%b", got.sum, got.n, got.z, got.c, got.v);
                    end
                    if (lat_check) chk("latency", 32'(cyc - ent.issue_cyc), 32'(S));
                end
            end
            stalled = out_valid && !out_ready;
            held    = got;
        end
    end

    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       begin out_ready = (k % 4 == 0) || (k % 4 == 3); k++; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic cin, input res_t e);
        int guard = 0;
        bit acc;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin; cur_exp = e;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int guard = 0;
        in_valid   = 1'b0;
        ready_mode = 0;
        while (sbq.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    vec_t tbl[13];

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   op;
        logic         ci;

        tbl[0]  = mk(16'h1234, 16'h1111, 2'b00, 1'b0, 16'h2345, 0, 0, 0, 0);
        tbl[1]  = mk(16'h0005, 16'h0007, 2'b01, 1'b0, 16'hFFFE, 1, 0, 0, 0);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        tbl[2]  = mk(16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h7FFF, 0, 0, 0, 1);
        tbl[7]  = mk(16'h8000, 16'h0001, 2'b01, 1'b0, 16'h8000, 1, 0, 1, 1);
        tbl[12] = mk(16'h8000, 16'h8000, 2'b00, 1'b0, 16'h8000, 1, 0, 1, 1);
`else
        tbl[2]  = mk(16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1, 0, 0, 1);
        tbl[7]  = mk(16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7FFF, 0, 0, 1, 1);
        tbl[12] = mk(16'h8000, 16'h8000, 2'b00, 1'b0, 16'h0000, 0, 1, 1, 1);
`endif
        tbl[3]  = mk(16'hFFFF, 16'h0000, 2'b10, 1'b1, 16'h0000, 0, 1, 1, 0);
        tbl[4]  = mk(16'h0000, 16'h0000, 2'b11, 1'b0, 16'hFFFF, 1, 0, 0, 0);
        tbl[5]  = mk(16'h0000, 16'h0001, 2'b01, 1'b0, 16'hFFFF, 1, 0, 0, 0);
        tbl[6]  = mk(16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 0, 1, 1, 0);
        tbl[8]  = mk(16'h0001, 16'h0001, 2'b10, 1'b1, 16'h0003, 0, 0, 0, 0);
        tbl[9]  = mk(16'h0005, 16'h0003, 2'b11, 1'b1, 16'h0002, 0, 0, 1, 0);
        tbl[10] = mk(16'h0001, 16'h0001, 2'b00, 1'b1, 16'h0002, 0, 0, 0, 0);
        tbl[11] = mk(16'h0003, 16'h0003, 2'b01, 1'b0, 16'h0000, 0, 1, 1, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_flags", 32'({out_n, out_z, out_c, out_v}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Directed table, back-to-back, latency checked
        lat_check = 1'b1;
        for (int i = 0; i < 13; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].cin, tbl[i].exp);
        drain();

        // Reset one cycle after an issue: nothing may ever appear
        send(16'h1234, 16'h1111, 2'b00, 1'b0, tbl[0].exp);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midflight_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Six ops under 1,0,0,1 back-pressure
        lat_check  = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); ci = 1'($urandom_range(0, 1));
            send(a, b, op, ci, model(a, b, op, ci));
        end
        drain();

        // Random traffic with random stalls and input gaps
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); ci = 1'($urandom_range(0, 1));
            send(a, b, op, ci, model(a, b, op, ci));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Full-rate random stream, latency checked
        lat_check = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); ci = 1'($urandom_range(0, 1));
            send(a, b, op, ci, model(a, b, op, ci));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
